// File: rtl/serial_frame_ctrl_pkg.sv
// Shared types and timing constants for the serial frame controller.
// Tick counts are in units of half sclk periods.
package serial_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } state_e;

    localparam int SETUP_TICKS         = 1;
    localparam int SHIFT_TICKS_PER_BIT = 2;
    localparam int HOLD_TICKS          = 2;

    function automatic int frame_ticks(input int width);
        return SETUP_TICKS + SHIFT_TICKS_PER_BIT * width - 1 + HOLD_TICKS;
    endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// Free-running half-period divider; tick marks the last clk of each
// half sclk period while run is high.
module sclk_tick_gen #(
    parameter int DIV_BITS = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    logic [DIV_BITS-1:0] cnt_q;
    logic [DIV_BITS-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (run) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = &cnt_q;

endmodule

// File: rtl/serial_frame_ctrl.sv
// Single-frame serial master: MSB-first shift out on sdo, shift in
// from sdi on rising sclk, framed by cs_n with a setup and hold time.
module serial_frame_ctrl
    import serial_frame_ctrl_pkg::*;
#(
    parameter int DIV_BITS = 5,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             sdi,
    output logic             sclk,
    output logic             sdo,
    output logic             cs_n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH);
    localparam logic [1:0] HOLD_LAST = 2'(HOLD_TICKS - 1);

    state_e state_q, state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]       hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic sclk_q, sclk_d;
    logic sdo_q, sdo_d;
    logic cs_n_q, cs_n_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic tick;
    logic run;

    assign run = (state_q != ST_IDLE);

    sclk_tick_gen #(
        .DIV_BITS(DIV_BITS)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .run (run),
        .tick(tick)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        hold_cnt_d = hold_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        sclk_d     = sclk_q;
        sdo_d      = sdo_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SETUP;
                    tx_sr_d    = tx_data;
                    sdo_d      = tx_data[WIDTH-1];
                    cs_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    bit_cnt_d  = '0;
                    hold_cnt_d = '0;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d   = ST_SHIFT;
                    sclk_d    = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    rx_sr_d   = {rx_sr_q[WIDTH-2:0], sdi};
                end
            end
            ST_SHIFT: begin
                if (tick && sclk_q) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_HOLD;
                        sdo_d   = 1'b0;
                    end else begin
                        sdo_d   = tx_sr_q[WIDTH-2];
                        tx_sr_d = tx_sr_q << 1;
                    end
                end else if (tick) begin
                    sclk_d    = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    rx_sr_d   = {rx_sr_q[WIDTH-2:0], sdi};
                end
            end
            ST_HOLD: begin
                // cs_n stays low for two half periods after the last edge
                if (tick && hold_cnt_q == HOLD_LAST) begin
                    state_d   = ST_IDLE;
                    cs_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sr_q;
                end else if (tick) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            sclk_q     <= 1'b0;
            sdo_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            sclk_q     <= sclk_d;
            sdo_q      <= sdo_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sclk    = sclk_q;
    assign sdo     = sdo_q;
    assign cs_n    = cs_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Randomized bench for serial_frame_ctrl against a timing-arithmetic
// reference model of one frame.
module tb_serial_frame_ctrl;

    localparam int DB    = 2;
    localparam int W     = 8;
    localparam int H     = 1 << DB;
    localparam int FRAME = H * (2 * W + 2);

    localparam int M_LOOP = 0;
    localparam int M_ONE  = 1;
    localparam int M_RAND = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] tx_data;
    logic         sdi;
    logic         sclk;
    logic         sdo;
    logic         cs_n;
    logic         busy;
    logic         done;
    logic [W-1:0] rx_data;

    serial_frame_ctrl #(
        .DIV_BITS(DB),
        .WIDTH   (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .tx_data(tx_data),
        .sdi    (sdi),
        .sclk   (sclk),
        .sdo    (sdo),
        .cs_n   (cs_n),
        .busy   (busy),
        .done   (done),
        .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int mode = M_LOOP;

    // reference model state
    bit           m_busy = 0;
    int           m_t0 = 0;
    logic [W-1:0] m_data = '0;
    logic [W-1:0] m_rx = '0;
    logic [W-1:0] e_rx = '0;
    bit           e_done, e_sclk, e_sdo;

    // observation counters
    int  done_cnt = 0;
    int  last_done = 0;
    int  rises = 0;
    int  low_cnt = 0;
    bit  prev_sclk = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h",
                     tag, cyc, obs, exp);
        end
    endtask

    task automatic derive();
        int k;
        k = cyc - m_t0;
        e_sclk = 0;
        e_sdo  = 0;
        if (m_busy) begin
            e_sclk = (k >= H) && (k < 2 * W * H) && ((k / H) % 2 == 1);
            if (k < 2 * W * H) e_sdo = m_data[W - 1 - k / (2 * H)];
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_rx   = '0;
        e_rx   = '0;
        e_done = 0;
        derive();
    endtask

    task automatic model_edge();
        int k;
        if (rst) begin
            model_reset();
        end else begin
            e_done = 0;
            if (m_busy) begin
                k = cyc - m_t0;
                if (k >= H && k < 2 * W * H && k % (2 * H) == H)
                    m_rx = {m_rx[W-2:0], sdi};
                if (k == FRAME) begin
                    e_done = 1;
                    m_busy = 0;
                    e_rx   = m_rx;
                end
            end else if (start) begin
                m_busy = 1;
                m_t0   = cyc;
                m_data = tx_data;
                rises  = 0;
            end
            derive();
        end
    endtask

    task automatic compare();
        chk("sclk", sclk, e_sclk);
        chk("sdo", sdo, e_sdo);
        chk("cs_n", cs_n, !m_busy);
        chk("busy", busy, m_busy);
        chk("done", done, e_done);
        chk("rx_data", rx_data, e_rx);
        if (sclk && !prev_sclk) rises++;
        prev_sclk = sclk;
        if (!cs_n) low_cnt++;
        if (done) begin
            done_cnt++;
            last_done = cyc;
            chk("rises", rises, W);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        compare();
        unique case (mode)
            M_LOOP:  sdi = sdo;
            M_ONE:   sdi = 1'b1;
            default: sdi = 1'($urandom);
        endcase
    endtask

    task automatic run_frame();
        int n;
        n = 0;
        while (m_busy && n < 4 * FRAME) begin
            step();
            n++;
        end
        chk("frame_end", busy, 0);
        step();
    endtask

    int acc;
    int d0;

    initial begin
        rst = 1'b1;
        start = 1'b1;
        tx_data = '0;
        sdi = 1'b0;
        model_reset();
        repeat (3) step();
        chk("rst_csn", cs_n, 1);
        rst = 1'b0;
        start = 1'b0;
        step();

        // loopback frame, first start after reset
        mode = M_LOOP;
        sdi = sdo;
        tx_data = 8'hA5;
        start = 1'b1;
        step();
        acc = cyc;
        start = 1'b0;
        tx_data = 8'($urandom);
        run_frame();
        chk("lb_rx", rx_data, 8'hA5);
        chk("lb_lat", last_done - acc, FRAME);

        // sdi tied high, all-zero data
        mode = M_ONE;
        sdi = 1'b1;
        tx_data = 8'h00;
        start = 1'b1;
        low_cnt = 0;
        step();
        acc = cyc;
        start = 1'b0;
        run_frame();
        chk("one_rx", rx_data, 8'hFF);
        chk("csn_low", low_cnt, FRAME);

        // start held high: back-to-back frames
        mode = M_RAND;
        d0 = done_cnt;
        start = 1'b1;
        for (int i = 0; i < 3 * (FRAME + 1); i++) begin
            tx_data = 8'($urandom);
            step();
        end
        start = 1'b0;
        run_frame();
        chk("b2b_dones", done_cnt - d0, 3);

        // random starts and data changes while busy
        for (int i = 0; i < 900; i++) begin
            start = ($urandom % 8) == 0;
            tx_data = 8'($urandom);
            step();
        end
        start = 1'b0;
        run_frame();

        // abort mid-frame
        mode = M_LOOP;
        tx_data = 8'h5A;
        start = 1'b1;
        step();
        start = 1'b0;
        d0 = done_cnt;
        repeat (29) step();
        #2;
        rst = 1'b1;
        start = 1'b1;
        #1;
        model_reset();
        chk("abort_sclk", sclk, 0);
        chk("abort_csn", cs_n, 1);
        chk("abort_busy", busy, 0);
        chk("abort_rx", rx_data, 0);
        repeat (2) step();
        rst = 1'b0;
        tx_data = 8'h3C;
        step();
        acc = cyc;
        start = 1'b0;
        run_frame();
        chk("abort_dones", done_cnt - d0, 1);
        chk("post_rx", rx_data, 8'h3C);
        chk("post_lat", last_done - acc, FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
